// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter that lets NUM_REQ requesters share the write port of a
// single FIFO. A winner is picked in IDLE. It then holds the port in BURST for
// up to MAX_BURST beats, or until it drops its valid. Each new grant costs
// exactly one idle (bubble) cycle. Writes stall while the FIFO reports full.
//
// Parameters
//   DATA_WIDTH  width of each requester word and of the FIFO write word
//   NUM_REQ     number of requesters (2..8)
//   MAX_BURST   maximum beats per grant (1..16)
//
// Ports
//   w_clk       clock, all state on the rising edge
//   wrst        asynchronous active-low reset
//   req_valid   per-requester "word available"
//   req_data    packed requester words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready   per-requester "word accepted this cycle"
//   fifo_full   FIFO full flag
//   wr_req      FIFO write strobe
//   data_in     FIFO write data (word of the granted requester)
//   grant_id    current or most recent granted requester
//   busy        high while a burst is in progress
//   grant_cnt   (only with FIFO_ARB_STATS_EN) saturating 16-bit grant count
//               per requester, counter i at [i*16 +: 16]
//
// Optional feature macro: FIFO_ARB_STATS_EN
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REQ    = 4,
   parameter int MAX_BURST  = 4
) (
   input  logic                          w_clk,
   input  logic                          wrst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          wr_req,
   output logic [DATA_WIDTH-1:0]         data_in,
   output logic [2:0]                    grant_id,
   output logic                          busy
`ifdef FIFO_ARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0]         grant_cnt
`endif
);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   // After reset the pointer sits on the last requester so requester 0 wins first.
   localparam logic [2:0] RST_GRANT = 3'(NUM_REQ - 1);
   localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

   state_t     state;
   state_t     state_nxt;
   logic [2:0] grant_nxt;
   logic [3:0] beat_cnt;
   logic [3:0] beat_nxt;
   logic       arb_hit;
   logic [2:0] arb_id;
   logic       sel_valid;

   // Requester selected by grant_id: its valid flag and its data word.
   always_comb begin
      sel_valid = 1'b0;
      data_in   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (int'(grant_id) == i) begin
            sel_valid = req_valid[i];
            data_in   = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Round-robin search: candidate offsets 1..NUM_REQ from the last grant.
   // Offset NUM_REQ wraps back to the last grantee, so a lone requester is
   // re-granted.
   always_comb begin
      arb_hit = 1'b0;
      arb_id  = grant_id;
      for (int k = 1; k <= NUM_REQ; k++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!arb_hit && req_valid[i] &&
                (i == ((int'(grant_id) + k) % NUM_REQ))) begin
               arb_hit = 1'b1;
               arb_id  = 3'(i);
            end
         end
      end
   end

   always_ff @(posedge w_clk or negedge wrst) begin
      if (!wrst) begin
         state    <= IDLE;
         grant_id <= RST_GRANT;
         beat_cnt <= '0;
      end else begin
         state    <= state_nxt;
         grant_id <= grant_nxt;
         beat_cnt <= beat_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      grant_nxt = grant_id;
      beat_nxt  = beat_cnt;
      wr_req    = 1'b0;
      req_ready = '0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            if (arb_hit) begin
               state_nxt = BURST;
               grant_nxt = arb_id;
               beat_nxt  = '0;
            end
         end
         BURST: begin
            busy   = 1'b1;
            wr_req = sel_valid & ~fifo_full;
            for (int i = 0; i < NUM_REQ; i++) begin
               req_ready[i] = (int'(grant_id) == i) && !fifo_full;
            end
            // A dropped valid ends the burst even while the FIFO is full;
            // otherwise a full FIFO simply freezes everything.
            if (!sel_valid) begin
               state_nxt = IDLE;
            end else if (wr_req) begin
               beat_nxt = beat_cnt + 4'd1;
               if (beat_cnt == LAST_BEAT) begin
                  state_nxt = IDLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

`ifdef FIFO_ARB_STATS_EN
   // One saturating counter per requester, bumped on every IDLE->BURST grant.
   always_ff @(posedge w_clk or negedge wrst) begin
      if (!wrst) begin
         grant_cnt <= '0;
      end else if ((state == IDLE) && arb_hit) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if ((int'(arb_id) == i) && (grant_cnt[i*16 +: 16] != 16'hFFFF)) begin
               grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
            end
         end
      end
   end
`endif

endmodule
